// File: rtl/fir_resampler_sched.sv
// Polyphase request scheduler: buffers input samples in a 2-entry FIFO and
// issues one compute request per output tick to an external FIR resampler,
// tracking the polyphase accumulator and the "consume new sample" flag.
module fir_resampler_sched #(
  parameter int unsigned INTERPOLATION = 32,
  parameter int unsigned DECIMATION    = 25,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned PHASE_WIDTH   = $clog2(INTERPOLATION)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  input  logic                   s_val_i,
  output logic                   s_rdy_o,
  input  logic                   tick_i,
  output logic [DATA_WIDTH-1:0]  fir_data_o,
  output logic                   fir_val_o,
  output logic                   fir_req_o,
  input  logic                   fir_done_i,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   busy_o,
  output logic [2:0]             err_flg_o
);

  localparam int unsigned SUM_W = PHASE_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q;
  logic                   pend_q;
  logic [CNT_W-1:0]       wcnt_q;
  logic                   req_q, val_q, busy_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [2:0]             err_q;

  logic [DATA_WIDTH-1:0]  mem_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             cnt_q;

  logic                   full, empty, push, pop, start;
  logic                   underrun, overrun, timeout_hit;
  logic [SUM_W-1:0]       sum;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign push  = s_val_i && !full;

  // A request starts from IDLE on a tick, or from WAIT when done and tick coincide
  assign start = tick_i && ((state_q == IDLE) || ((state_q == WAIT) && fir_done_i));
  assign pop   = start && pend_q && !empty;

  assign underrun    = start && pend_q && empty;
  assign overrun     = tick_i && ((state_q == ISSUE) || ((state_q == WAIT) && !fir_done_i));
  assign timeout_hit = (state_q == WAIT) && !fir_done_i && (wcnt_q == CNT_W'(TIMEOUT - 2));

  assign sum = {1'b0, acc_q} + SUM_W'(DECIMATION);

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fir_done_i)       state_d = start ? ISSUE : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state, phase accumulator and registered request outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pend_q  <= 1'b1;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      val_q   <= 1'b0;
      data_q  <= '0;
      phase_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      req_q   <= 1'b0;
      val_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= err_q | {timeout_hit, overrun, underrun};

      if (state_q == ISSUE) begin
        wcnt_q <= '0;
        if (sum >= SUM_W'(INTERPOLATION)) begin
          acc_q  <= PHASE_WIDTH'(sum - SUM_W'(INTERPOLATION));
          pend_q <= 1'b1;
        end else begin
          acc_q  <= PHASE_WIDTH'(sum);
          pend_q <= 1'b0;
        end
      end else if ((state_q == WAIT) && !fir_done_i && !timeout_hit) begin
        wcnt_q <= wcnt_q + CNT_W'(1);
      end

      if (start) begin
        req_q   <= 1'b1;
        val_q   <= pend_q;
        data_q  <= pop ? mem_q[rd_ptr_q] : '0;
        phase_q <= acc_q;
      end
    end
  end

  // Two-entry input FIFO; simultaneous push and pop both take effect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign s_rdy_o    = !rst_i && !full;
  assign fir_req_o  = req_q;
  assign fir_val_o  = val_q;
  assign fir_data_o = data_q;
  assign phase_o    = phase_q;
  assign busy_o     = busy_q;
  assign err_flg_o  = err_q;

endmodule
